// File: rtl/uart_pkg.sv
// Shared UART types: the arbiter FSM encoding plus the transmitter and receiver state enums
// used by the rest of the UART subsystem.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      ARB_IDLE      = 2'd0,
      ARB_START     = 2'd1,
      ARB_WAIT_BUSY = 2'd2,
      ARB_WAIT_DONE = 2'd3
   } arb_state_t;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set bit of req searching upward from rr_ptr with wrap.
// Shared by the transmit arbiter and the receive-side dispatcher.
module rr_select #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   sel,
   output logic               any_req
);

   // One extra bit so rr_ptr + offset never overflows before the explicit modulo.
   localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

   logic [IDX_W:0] idx;

   always_comb begin
      sel     = '0;
      any_req = 1'b0;
      idx     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = {1'b0, rr_ptr} + (IDX_W+1)'(i);
         if (idx >= NUM_REQ_W) begin
            idx = idx - NUM_REQ_W;
         end
         if (!any_req && req[idx[IDX_W-1:0]]) begin
            any_req = 1'b1;
            sel     = idx[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Latches one byte per grant and releases the transmitter only after the frame completes.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DATA_W       = UART_DATA_W,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        tx_start,
   output logic [DATA_W-1:0]           tx_data,
   input  logic                        tx_busy,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        active,
   output logic                        timeout_err
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

   localparam logic [IDX_W-1:0] LAST_ID  = IDX_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

   arb_state_t          state;
   logic [IDX_W-1:0]    rr_ptr;
   logic [CNT_W-1:0]    busy_cnt;
   logic [IDX_W-1:0]    sel;
   logic                any_req;
   logic [DATA_W-1:0]   sel_data;
   logic [NUM_REQ-1:0]  sel_onehot;
   logic [IDX_W-1:0]    next_ptr;

   rr_select #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_select (
      .req     (req_valid),
      .rr_ptr  (rr_ptr),
      .sel     (sel),
      .any_req (any_req)
   );

   always_comb begin
      sel_data   = '0;
      sel_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel == IDX_W'(i)) begin
            sel_data      = req_data[i*DATA_W +: DATA_W];
            sel_onehot[i] = 1'b1;
         end
      end
   end

   // Explicit wrap so non-power-of-two NUM_REQ still cycles 0..NUM_REQ-1.
   assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= ARB_IDLE;
         rr_ptr      <= '0;
         busy_cnt    <= '0;
         req_ready   <= '0;
         tx_start    <= 1'b0;
         tx_data     <= '0;
         grant_id    <= '0;
         active      <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         req_ready   <= '0;
         tx_start    <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (any_req) begin
                  tx_data   <= sel_data;
                  grant_id  <= sel;
                  req_ready <= sel_onehot;
                  active    <= 1'b1;
                  state     <= ARB_START;
               end
            end
            ARB_START: begin
               // A previous frame may still be draining; wait for it before starting ours.
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  busy_cnt <= '0;
                  state    <= ARB_WAIT_BUSY;
               end
            end
            ARB_WAIT_BUSY: begin
               if (tx_busy) begin
                  state <= ARB_WAIT_DONE;
               end else if (busy_cnt == CNT_LAST) begin
                  timeout_err <= 1'b1;
                  rr_ptr      <= next_ptr;
                  active      <= 1'b0;
                  state       <= ARB_IDLE;
               end else begin
                  busy_cnt <= busy_cnt + 1'b1;
               end
            end
            ARB_WAIT_DONE: begin
               if (!tx_busy) begin
                  rr_ptr <= next_ptr;
                  active <= 1'b0;
                  state  <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model whose busy time
// can be stretched, suppressed, or overridden.
module tb_uart_tx_arbiter;

   logic        clk;
   logic        rstn;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic [1:0]  grant_id;
   logic        active;
   logic        timeout_err;

   int checks = 0;
   int errors = 0;

   logic model_busy;
   int   busy_left;
   int   frame_len = 160;
   bit   no_busy   = 1'b0;
   logic hold_busy = 1'b0;

   logic [7:0] log_data[$];
   logic [1:0] log_gid[$];

   uart_tx_arbiter #(
      .NUM_REQ      (4),
      .DATA_W       (8),
      .BUSY_TIMEOUT (16)
   ) u_dut (
      .clk         (clk),
      .rstn        (rstn),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .grant_id    (grant_id),
      .active      (active),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign tx_busy = model_busy | hold_busy;

   // Transmitter model: busy for frame_len cycles starting the cycle after tx_start.
   always @(posedge clk) begin
      if (!rstn) begin
         model_busy <= 1'b0;
         busy_left  <= 0;
      end else if (tx_start && !no_busy) begin
         model_busy <= 1'b1;
         busy_left  <= frame_len;
      end else if (busy_left > 1) begin
         busy_left <= busy_left - 1;
      end else begin
         model_busy <= 1'b0;
         busy_left  <= 0;
      end
   end

   always @(posedge clk) begin
      if (rstn && tx_start) begin
         log_data.push_back(tx_data);
         log_gid.push_back(grant_id);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_frames(input int n, input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (log_data.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idle(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (active == 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rstn      = 1'b0;
      req_valid = '0;
      req_data  = '0;
      repeat (3) @(negedge clk);
      checks++; if (req_ready !== 4'b0)   begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
      checks++; if (tx_start !== 1'b0)    begin errors++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
      checks++; if (tx_data !== 8'h00)    begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
      checks++; if (grant_id !== 2'd0)    begin errors++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
      checks++; if (active !== 1'b0)      begin errors++; $display("FAIL reset_active got %b want 0", active); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
      rstn = 1'b1;
   endtask

   task automatic test_single;
      int  n_busy;
      bit  stable_ok;
      frame_len = 160;
      @(negedge clk);
      req_data         = '0;
      req_data[23:16]  = 8'hA5;
      req_valid        = 4'b0100;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
      checks++; if (grant_id !== 2'd2)     begin errors++; $display("FAIL single_grant got %0d want 2", grant_id); end
      checks++; if (active !== 1'b1)       begin errors++; $display("FAIL single_active got %b want 1", active); end
      checks++; if (tx_data !== 8'hA5)     begin errors++; $display("FAIL single_data got %h want a5", tx_data); end
      checks++; if (tx_start !== 1'b0)     begin errors++; $display("FAIL single_early_start got %b want 0", tx_start); end
      req_valid = '0;
      @(negedge clk);
      checks++; if (tx_start !== 1'b1)     begin errors++; $display("FAIL single_start got %b want 1", tx_start); end
      checks++; if (req_ready !== 4'b0)    begin errors++; $display("FAIL single_ready_pulse got %b want 0000", req_ready); end
      n_busy    = 0;
      stable_ok = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!tx_busy) break;
         n_busy++;
         if (tx_data !== 8'hA5 || active !== 1'b1 || tx_start !== 1'b0) stable_ok = 1'b0;
      end
      checks++; if (n_busy != 160)        begin errors++; $display("FAIL single_busy_len got %0d want 160", n_busy); end
      checks++; if (!stable_ok)           begin errors++; $display("FAIL single_hold got unstable want tx_data=a5 active=1"); end
      checks++; if (active !== 1'b1)      begin errors++; $display("FAIL single_active_at_drop got %b want 1", active); end
      @(negedge clk);
      checks++; if (active !== 1'b0)      begin errors++; $display("FAIL single_active_fall got %b want 0", active); end
      checks++; if (grant_id !== 2'd2)    begin errors++; $display("FAIL single_grant_hold got %0d want 2", grant_id); end
   endtask

   task automatic test_round_robin;
      bit ok;
      logic [7:0] exp_d;
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn      = 1'b1;
      frame_len = 4;
      log_data.delete();
      log_gid.delete();
      req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
      req_valid = 4'b1111;
      wait_frames(5, 500, ok);
      req_valid = '0;
      checks++; if (!ok) begin errors++; $display("FAIL rr_frames got %0d want 5", log_data.size()); end
      wait_idle(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_idle got active=%b want 0", active); end
      for (int i = 0; i < 5; i++) begin
         exp_d = 8'h10 + 8'(i % 4);
         checks++;
         if (i >= log_data.size() || log_data[i] !== exp_d) begin
            errors++; $display("FAIL rr_order[%0d] got %h want %h", i, (i < log_data.size()) ? log_data[i] : 8'hxx, exp_d);
         end
         checks++;
         if (i >= log_gid.size() || log_gid[i] !== 2'(i % 4)) begin
            errors++; $display("FAIL rr_gid[%0d] got %0d want %0d", i, (i < log_gid.size()) ? log_gid[i] : 2'bxx, i % 4);
         end
      end
   endtask

   task automatic test_fairness_wrap;
      bit ok;
      log_data.delete();
      log_gid.delete();
      req_data[31:24] = 8'h33;
      req_valid       = 4'b1000;
      wait_frames(1, 200, ok);
      req_valid = '0;
      wait_idle(200, ok);
      checks++; if (log_gid.size() < 1 || log_gid[0] !== 2'd3) begin errors++; $display("FAIL wrap_first got size=%0d want grant 3", log_gid.size()); end
      log_data.delete();
      log_gid.delete();
      req_data[7:0]   = 8'h40;
      req_data[31:24] = 8'h43;
      req_valid       = 4'b1001;
      wait_frames(2, 300, ok);
      req_valid = '0;
      checks++; if (!ok) begin errors++; $display("FAIL wrap_frames got %0d want 2", log_data.size()); end
      wait_idle(200, ok);
      checks++; if (log_gid.size() < 2 || log_gid[0] !== 2'd0 || log_gid[1] !== 2'd3) begin
         errors++; $display("FAIL wrap_order got size=%0d want grants 0 then 3", log_gid.size());
      end
      checks++; if (log_data.size() < 2 || log_data[0] !== 8'h40 || log_data[1] !== 8'h43) begin
         errors++; $display("FAIL wrap_data got size=%0d want 40 then 43", log_data.size());
      end
   endtask

   task automatic test_busy_at_start;
      bit ok;
      bit early;
      @(negedge clk);
      hold_busy      = 1'b1;
      req_data[15:8] = 8'h77;
      req_valid      = 4'b0010;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL busy_ready got %b want 0010", req_ready); end
      req_valid = '0;
      early = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx_start !== 1'b0) early = 1'b1;
      end
      checks++; if (early) begin errors++; $display("FAIL busy_hold_start got pulse want none while busy"); end
      hold_busy = 1'b0;
      @(negedge clk);
      checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL busy_release_start got %b want 1", tx_start); end
      checks++; if (tx_data !== 8'h77) begin errors++; $display("FAIL busy_data got %h want 77", tx_data); end
      @(negedge clk);
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL busy_single_pulse got %b want 0", tx_start); end
      wait_idle(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL busy_idle got active=%b want 0", active); end
   endtask

   task automatic test_timeout;
      int n;
      bit ok;
      @(negedge clk);
      no_busy         = 1'b1;
      req_data[23:16] = 8'h5C;
      req_valid       = 4'b0100;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL to_ready got %b want 0100", req_ready); end
      req_valid = '0;
      @(negedge clk);
      checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL to_start got %b want 1", tx_start); end
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         n++;
         if (timeout_err === 1'b1) break;
      end
      checks++; if (n != 16)             begin errors++; $display("FAIL to_latency got %0d want 16", n); end
      checks++; if (active !== 1'b0)     begin errors++; $display("FAIL to_active got %b want 0", active); end
      checks++; if (tx_data !== 8'h5C)   begin errors++; $display("FAIL to_data got %h want 5c", tx_data); end
      @(negedge clk);
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_pulse_width got %b want 0", timeout_err); end
      no_busy         = 1'b0;
      req_data[31:24] = 8'h6D;
      req_valid       = 4'b1100;
      @(negedge clk);
      checks++; if (grant_id !== 2'd3)     begin errors++; $display("FAIL to_next_grant got %0d want 3", grant_id); end
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL to_next_ready got %b want 1000", req_ready); end
      req_valid = '0;
      wait_idle(200, ok);
   endtask

   task automatic test_reset_mid_frame;
      bit ok;
      frame_len       = 4;
      req_data[23:16] = 8'h88;
      req_valid       = 4'b0100;
      @(negedge clk);
      req_valid = '0;
      wait_idle(200, ok);
      frame_len       = 50;
      req_data[31:24] = 8'h99;
      req_valid       = 4'b1000;
      @(negedge clk);
      req_valid = '0;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx_busy) begin ok = 1'b1; break; end
      end
      repeat (3) @(negedge clk);
      checks++; if (!ok || active !== 1'b1 || tx_busy !== 1'b1) begin
         errors++; $display("FAIL mid_setup got busy=%b active=%b want 1 1", tx_busy, active);
      end
      rstn = 1'b0;
      @(negedge clk);
      checks++; if (tx_data !== 8'h00)      begin errors++; $display("FAIL mid_tx_data got %h want 00", tx_data); end
      checks++; if (grant_id !== 2'd0)      begin errors++; $display("FAIL mid_grant got %0d want 0", grant_id); end
      checks++; if (active !== 1'b0)        begin errors++; $display("FAIL mid_active got %b want 0", active); end
      checks++; if (u_dut.rr_ptr !== 2'd0)  begin errors++; $display("FAIL mid_rr_ptr got %0d want 0", u_dut.rr_ptr); end
      checks++; if (req_ready !== 4'b0 || tx_start !== 1'b0 || timeout_err !== 1'b0) begin
         errors++; $display("FAIL mid_pulses got ready=%b start=%b to=%b want 0", req_ready, tx_start, timeout_err);
      end
      rstn      = 1'b1;
      frame_len = 4;
      log_data.delete();
      log_gid.delete();
      req_data[15:8] = 8'h21;
      req_valid      = 4'b0010;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0010 || grant_id !== 2'd1) begin
         errors++; $display("FAIL mid_regrant got ready=%b grant=%0d want 0010 1", req_ready, grant_id);
      end
      req_valid = '0;
      wait_frames(1, 100, ok);
      checks++; if (!ok || log_data[0] !== 8'h21) begin errors++; $display("FAIL mid_regrant_data got size=%0d want 21", log_data.size()); end
      wait_idle(200, ok);
   endtask

   initial begin
      rstn      = 1'b0;
      req_valid = '0;
      req_data  = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_fairness_wrap();
      test_busy_at_start();
      test_timeout();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
